// File: rtl/add8u_pkg.sv
// add8u_pkg: shared widths, FSM state encoding and stage-1 payload type
// for the 8-bit approximate-adder error monitor.
package add8u_pkg;

    localparam int unsigned OP_W  = 8;   // operand width
    localparam int unsigned SUM_W = 9;   // exact / observed sum width
    localparam int unsigned ERR_W = 9;   // absolute error width (0..511)
    localparam int unsigned ACC_W = 25;  // covers 65536 * 511
    localparam int unsigned CNT_W = 17;  // covers 65536

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Stage-1 result consumed by the stage-2 accumulators
    typedef struct packed {
        logic [ERR_W-1:0] abs_err;
        logic             mismatch;
    } s1_t;

endpackage

// File: rtl/add8u_err_stage.sv
// add8u_err_stage: combinational stage-1 logic. Forms the exact 9-bit sum
// of A+B, the absolute distance to the observed sum O and a mismatch flag.
// Ports:
//   a_i, b_i    operands fed to the adder under test
//   o_i         sum reported by the adder under test
//   res_o       {abs_err, mismatch}
module add8u_err_stage
    import add8u_pkg::*;
(
    input  logic [OP_W-1:0]  a_i,
    input  logic [OP_W-1:0]  b_i,
    input  logic [SUM_W-1:0] o_i,
    output s1_t              res_o
);

    logic [SUM_W-1:0] exact;
    logic [ERR_W-1:0] abs_err;

    assign exact = SUM_W'(a_i) + SUM_W'(b_i);

    // Subtract the smaller from the larger so the result never wraps
    assign abs_err = (exact >= o_i) ? ERR_W'(exact - o_i) : ERR_W'(o_i - exact);

    assign res_o.abs_err  = abs_err;
    assign res_o.mismatch = (abs_err != '0);

endmodule

// File: rtl/add8u_err_monitor.sv
// add8u_err_monitor: collects SAMPLE_CNT (A, B, O) samples from an 8-bit
// approximate adder and accumulates total absolute error, worst-case error
// and the number of erroneous samples.
// Ports:
//   clk, rst              clock, async active-high reset
//   start                 pulse; begins a run from IDLE or DONE
//   in_valid / in_ready   sample handshake (ready only in RUN)
//   A, B, O               operands and observed sum
//   busy                  high in RUN and DRAIN
//   done                  high in DONE; results valid
//   sum_abs_err, wce, err_cnt  accumulated results
module add8u_err_monitor
    import add8u_pkg::*;
#(
    parameter int unsigned SAMPLE_CNT = 65536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  A,
    input  logic [OP_W-1:0]  B,
    input  logic [SUM_W-1:0] O,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] sum_abs_err,
    output logic [ERR_W-1:0] wce,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLE_CNT - 1);

    state_e           state_q;
    logic             in_ready_q, busy_q, done_q, drain_q;
    logic [CNT_W-1:0] cnt_q;

    s1_t              s1_c, s1_q;
    logic             s1_vld_q;

    logic [ACC_W-1:0] sum_q, sum_d;
    logic [ERR_W-1:0] wce_q, wce_d;
    logic [CNT_W-1:0] err_q, err_d;

    logic accept, last_accept, start_ok;

    assign accept      = in_valid && in_ready_q;
    assign last_accept = accept && (cnt_q == LAST_IDX);
    assign start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    add8u_err_stage u_stage (
        .a_i   (A),
        .b_i   (B),
        .o_i   (O),
        .res_o (s1_c)
    );

    // Control FSM; drain_q counts the two flush cycles of DRAIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            drain_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q    <= ST_RUN;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        cnt_q      <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (last_accept) begin
                        state_q    <= ST_DRAIN;
                        in_ready_q <= 1'b0;
                        drain_q    <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        drain_q <= 1'b0;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Stage-2 accumulation; start clears the totals for a new run
    always_comb begin
        sum_d = sum_q;
        wce_d = wce_q;
        err_d = err_q;
        if (start_ok) begin
            sum_d = '0;
            wce_d = '0;
            err_d = '0;
        end else if (s1_vld_q) begin
            sum_d = sum_q + ACC_W'(s1_q.abs_err);
            if (s1_q.abs_err > wce_q) begin
                wce_d = s1_q.abs_err;
            end
            err_d = err_q + CNT_W'(s1_q.mismatch);
        end
    end

    // Pipeline registers: stage 1 result plus the accumulators
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
            sum_q    <= '0;
            wce_q    <= '0;
            err_q    <= '0;
        end else begin
            s1_q     <= s1_c;
            s1_vld_q <= accept;
            sum_q    <= sum_d;
            wce_q    <= wce_d;
            err_q    <= err_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sum_abs_err = sum_q;
    assign wce         = wce_q;
    assign err_cnt     = err_q;

endmodule

// File: tb/tb_add8u_err_monitor.sv
// Bench for add8u_err_monitor. Four instances (SAMPLE_CNT = 4, 3, 1, 65536)
// share the sample inputs; only the selected instance is started at a time.
module tb_add8u_err_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] start_v;
    logic       in_valid;
    logic [7:0] a, b;
    logic [8:0] o;

    logic        rdy [4];
    logic        bsy [4];
    logic        dn  [4];
    logic [24:0] sm  [4];
    logic [8:0]  wc  [4];
    logic [16:0] ec  [4];

    int n_tests = 0;
    int n_fail  = 0;

    int qa[$], qb[$], qo[$];

    always #5 clk = ~clk;

    add8u_err_monitor #(.SAMPLE_CNT(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid), .in_ready(rdy[0]),
        .A(a), .B(b), .O(o), .busy(bsy[0]), .done(dn[0]),
        .sum_abs_err(sm[0]), .wce(wc[0]), .err_cnt(ec[0]));

    add8u_err_monitor #(.SAMPLE_CNT(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid), .in_ready(rdy[1]),
        .A(a), .B(b), .O(o), .busy(bsy[1]), .done(dn[1]),
        .sum_abs_err(sm[1]), .wce(wc[1]), .err_cnt(ec[1]));

    add8u_err_monitor #(.SAMPLE_CNT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(in_valid), .in_ready(rdy[2]),
        .A(a), .B(b), .O(o), .busy(bsy[2]), .done(dn[2]),
        .sum_abs_err(sm[2]), .wce(wc[2]), .err_cnt(ec[2]));

    add8u_err_monitor #(.SAMPLE_CNT(65536)) u_dutf (
        .clk(clk), .rst(rst), .start(start_v[3]), .in_valid(in_valid), .in_ready(rdy[3]),
        .A(a), .B(b), .O(o), .busy(bsy[3]), .done(dn[3]),
        .sum_abs_err(sm[3]), .wce(wc[3]), .err_cnt(ec[3]));

    task automatic chk(input string name, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_idle_zero(input int s, input string tag);
        chk({tag, "_ready"}, rdy[s], 0);
        chk({tag, "_busy"},  bsy[s], 0);
        chk({tag, "_done"},  dn[s],  0);
        chk({tag, "_sum"},   sm[s],  0);
        chk({tag, "_wce"},   wc[s],  0);
        chk({tag, "_cnt"},   ec[s],  0);
    endtask

    // One complete run on instance s using samples in qa/qb/qo.
    // vmode: 0 valid every cycle, 1 every other cycle, 2 random.
    // poke: pulse start once in RUN and once in DRAIN (must be ignored).
    task automatic run(input int s, input int vmode, input bit poke);
        int     n, idx, cyc, budget, e;
        longint es, ew, ecnt;
        logic   v;
        n = qa.size(); idx = 0; cyc = 0; budget = 4 * n + 16;
        es = 0; ew = 0; ecnt = 0;
        @(negedge clk);
        in_valid   = 1'b0;
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        chk("clr_sum", sm[s], 0);
        chk("clr_wce", wc[s], 0);
        chk("clr_cnt", ec[s], 0);
        chk("run_ready", rdy[s], 1);
        chk("run_busy", bsy[s], 1);
        chk("run_done", dn[s], 0);
        while (idx < n && cyc < budget) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            start_v[s] = poke && (cyc == 1);
            in_valid   = v;
            if (v) begin
                a = 8'(qa[idx]); b = 8'(qb[idx]); o = 9'(qo[idx]);
            end else begin
                a = 8'($urandom); b = 8'($urandom); o = 9'($urandom);
            end
            if (v && rdy[s]) begin
                e = qa[idx] + qb[idx] - qo[idx];
                if (e < 0) e = -e;
                es += e;
                if (e > ew) ew = e;
                if (e != 0) ecnt++;
                idx++;
            end
            cyc++;
            @(negedge clk);
        end
        chk("accepts", idx, n);
        // Cycle t+1 after the last acceptance: DRAIN, valid still offered
        in_valid   = 1'b1;
        a = 8'($urandom); b = 8'($urandom); o = 9'($urandom);
        start_v[s] = poke;
        chk("drain1_ready", rdy[s], 0);
        chk("drain1_busy", bsy[s], 1);
        chk("drain1_done", dn[s], 0);
        @(negedge clk);
        start_v[s] = 1'b0;
        chk("drain2_done", dn[s], 0);
        chk("drain2_busy", bsy[s], 1);
        chk("drain2_sum", sm[s], es);
        @(negedge clk);
        chk("done_rise", dn[s], 1);
        chk("done_busy", bsy[s], 0);
        chk("done_ready", rdy[s], 0);
        chk("done_sum", sm[s], es);
        chk("done_wce", wc[s], ew);
        chk("done_cnt", ec[s], ecnt);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("hold_done", dn[s], 1);
        chk("hold_sum", sm[s], es);
        chk("hold_cnt", ec[s], ecnt);
    endtask

    typedef struct {
        int s;
        int vmode;
        bit poke;
        int n;
        int sa[4];
        int sb[4];
        int so[4];
        int es;
        int ew;
        int ec;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s, n, x, y;
        rst = 1'b1; start_v = '0; in_valid = 1'b0; a = '0; b = '0; o = '0;

        tbl[0].s = 0; tbl[0].vmode = 0; tbl[0].poke = 0; tbl[0].n = 4;
        tbl[0].sa = '{255, 1, 0, 10}; tbl[0].sb = '{255, 1, 0, 5}; tbl[0].so = '{0, 3, 0, 13};
        tbl[0].es = 513; tbl[0].ew = 510; tbl[0].ec = 3;
        tbl[1].s = 1; tbl[1].vmode = 1; tbl[1].poke = 0; tbl[1].n = 3;
        tbl[1].sa = '{3, 200, 7, 0}; tbl[1].sb = '{4, 100, 7, 0}; tbl[1].so = '{7, 44, 0, 0};
        tbl[1].es = 270; tbl[1].ew = 256; tbl[1].ec = 2;
        tbl[2].s = 2; tbl[2].vmode = 0; tbl[2].poke = 0; tbl[2].n = 1;
        tbl[2].sa = '{0, 0, 0, 0}; tbl[2].sb = '{0, 0, 0, 0}; tbl[2].so = '{511, 0, 0, 0};
        tbl[2].es = 511; tbl[2].ew = 511; tbl[2].ec = 1;
        tbl[3].s = 0; tbl[3].vmode = 0; tbl[3].poke = 1; tbl[3].n = 4;
        tbl[3].sa = '{100, 0, 128, 9}; tbl[3].sb = '{100, 255, 128, 9}; tbl[3].so = '{0, 255, 1, 0};
        tbl[3].es = 473; tbl[3].ew = 255; tbl[3].ec = 3;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) chk_idle_zero(i, "reset");
        rst = 1'b0;

        // Directed table runs
        for (int i = 0; i < 4; i++) begin
            qa.delete(); qb.delete(); qo.delete();
            for (int j = 0; j < tbl[i].n; j++) begin
                qa.push_back(tbl[i].sa[j]); qb.push_back(tbl[i].sb[j]); qo.push_back(tbl[i].so[j]);
            end
            run(tbl[i].s, tbl[i].vmode, tbl[i].poke);
            chk("tbl_sum", sm[tbl[i].s], tbl[i].es);
            chk("tbl_wce", wc[tbl[i].s], tbl[i].ew);
            chk("tbl_cnt", ec[tbl[i].s], tbl[i].ec);
        end

        // Randomized runs against the model in run()
        for (int r = 0; r < 8; r++) begin
            s = (r == 7) ? 2 : r % 2;
            n = (s == 0) ? 4 : (s == 1) ? 3 : 1;
            qa.delete(); qb.delete(); qo.delete();
            for (int j = 0; j < n; j++) begin
                x = int'($urandom_range(0, 255));
                y = int'($urandom_range(0, 255));
                qa.push_back(x); qb.push_back(y);
                case ($urandom_range(0, 2))
                    0:       qo.push_back(x + y);
                    1:       qo.push_back((x + y >= 4) ? x + y - int'($urandom_range(0, 4)) : x + y + 1);
                    default: qo.push_back(int'($urandom_range(0, 511)));
                endcase
            end
            run(s, 2, r == 3);
        end

        // Reset in the middle of a run on the SAMPLE_CNT=4 instance
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        in_valid = 1'b1; a = 8'd200; b = 8'd100; o = 9'd0;
        @(negedge clk);
        chk("lat_c1_sum", sm[0], 0);
        a = 8'd50; b = 8'd50; o = 9'd90;
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_c2_sum", sm[0], 300);
        chk("lat_c2_cnt", ec[0], 1);
        rst = 1'b1;
        #1;
        chk_idle_zero(0, "async_rst");
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1; a = 8'd77; b = 8'd99; o = 9'd3;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        chk_idle_zero(0, "post_rst");
        qa = '{1, 2, 3, 4}; qb = '{1, 2, 3, 4}; qo = '{0, 0, 0, 0};
        run(0, 0, 0);
        chk("fresh_sum", sm[0], 20);
        chk("fresh_wce", wc[0], 8);
        chk("fresh_cnt", ec[0], 4);

        // Exhaustive exact run: every A,B pair with O = A+B
        qa.delete(); qb.delete(); qo.delete();
        for (int i = 0; i < 65536; i++) begin
            qa.push_back(i >> 8); qb.push_back(i & 255); qo.push_back((i >> 8) + (i & 255));
        end
        run(3, 0, 0);
        chk("full_sum", sm[3], 0);
        chk("full_wce", wc[3], 0);
        chk("full_cnt", ec[3], 0);
        chk("full_done", dn[3], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
